// File: rtl/argo_chan_pkg.sv
// Shared types and helpers for the Argo channel arbiter.
package argo_chan_pkg;

  // Width of the wrapping word counters.
  localparam int unsigned CNT_W = 32;

  // Read-side sequencing: grant, issue rd_en, wait out FIFO latency, deliver.
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DELIVER
  } rd_state_e;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/argo_rr_arbiter.sv
// Combinational round-robin search: first unmasked request at or above ptr,
// wrapping to the lowest index when nothing at or above ptr is pending.
module argo_rr_arbiter
  import argo_chan_pkg::*;
#(
  parameter int unsigned N  = 4,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  logic [N-1:0] eff_req;

  assign eff_req = req & ~mask;

  // Two descending scans: the first finds the lowest request overall (the
  // wrap-around candidate), the second overrides it with the lowest request
  // at or above ptr when one exists.
  always_comb begin
    // NOTE: every output gets a value before any branch, so no path through
    // this block leaves a signal unassigned and no latch is inferred.
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (en) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (eff_req[k]) begin
          grant_valid = 1'b1;
          grant_idx   = IW'(k);
        end
      end
      for (int k = N - 1; k >= 0; k--) begin
        if (eff_req[k] && (IW'(k) >= ptr)) begin
          grant_valid = 1'b1;
          grant_idx   = IW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/argo_chan_arbiter.sv
// Shares one argo_fifo channel between NUM_WR senders and NUM_RD receivers.
// Write side issues at most one word every two cycles (full lags the FIFO);
// read side keeps a single read in flight and routes the word to its owner.
module argo_chan_arbiter
  import argo_chan_pkg::*;
#(
  parameter int unsigned NUM_WR     = 4,
  parameter int unsigned NUM_RD     = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WR-1:0]            wr_req,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_WR-1:0]            wr_ack,
  input  logic [NUM_RD-1:0]            rd_req,
  output logic [NUM_RD-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         fifo_wr_en,
  output logic [DATA_WIDTH-1:0]        fifo_wr_data,
  input  logic                         fifo_full,
  output logic                         fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]        fifo_rd_data,
  input  logic                         fifo_empty,
  output logic [CNT_W-1:0]             wr_count,
  output logic [CNT_W-1:0]             rd_count
);

  localparam int unsigned WIW = idx_w(NUM_WR);
  localparam int unsigned RIW = idx_w(NUM_RD);
  localparam int unsigned LCW = idx_w(RD_LATENCY);

  // ---------------------------------------------------------------- write side
  logic [NUM_WR-1:0]     wr_ack_q, wr_ack_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_word_q, wr_word_d;
  logic [WIW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      wr_count_q, wr_count_d;

  logic                  wr_gnt_valid;
  logic [WIW-1:0]        wr_gnt_idx;
  logic [DATA_WIDTH-1:0] wr_sel_data;

  // A requester already holding its ack is masked so a held req is not
  // granted twice for the same word.
  argo_rr_arbiter #(.N(NUM_WR)) u_wr_arb (
    .req         (wr_req),
    .mask        (wr_ack_q),
    .ptr         (wr_ptr_q),
    .en          (~fifo_full & ~wr_en_q),
    .grant_valid (wr_gnt_valid),
    .grant_idx   (wr_gnt_idx)
  );

  // Select the winning sender's data slice with constant part-selects.
  always_comb begin
    wr_sel_data = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_gnt_idx == WIW'(k)) wr_sel_data = wr_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next write-side state: issue the winner or idle with data held.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see the
    // values just computed; registers below use '<=' so all flops update together.
    wr_ack_d   = '0;
    wr_en_d    = 1'b0;
    wr_word_d  = wr_word_q;
    wr_ptr_d   = wr_ptr_q;
    wr_count_d = wr_count_q;
    if (wr_gnt_valid) begin
      wr_ack_d   = NUM_WR'(1) << wr_gnt_idx;
      wr_en_d    = 1'b1;
      wr_word_d  = wr_sel_data;
      wr_ptr_d   = (wr_gnt_idx == WIW'(NUM_WR - 1)) ? '0 : wr_gnt_idx + 1'b1;
      wr_count_d = wr_count_q + 1'b1;
    end
  end

  // Write-side registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ack_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_word_q  <= '0;
      wr_ptr_q   <= '0;
      wr_count_q <= '0;
    end else begin
      wr_ack_q   <= wr_ack_d;
      wr_en_q    <= wr_en_d;
      wr_word_q  <= wr_word_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_count_q <= wr_count_d;
    end
  end

  // ----------------------------------------------------------------- read side
  rd_state_e             state_q, state_d;
  logic [RIW-1:0]        rd_idx_q, rd_idx_d;
  logic [LCW-1:0]        lat_cnt_q, lat_cnt_d;
  logic                  rd_en_q, rd_en_d;
  logic [NUM_RD-1:0]     rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [RIW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      rd_count_q, rd_count_d;

  logic                  rd_gnt_valid;
  logic [RIW-1:0]        rd_gnt_idx;

  // Only searched in IDLE with data available, so at most one read is in flight.
  argo_rr_arbiter #(.N(NUM_RD)) u_rd_arb (
    .req         (rd_req),
    .mask        ('0),
    .ptr         (rd_ptr_q),
    .en          ((state_q == IDLE) & ~fifo_empty),
    .grant_valid (rd_gnt_valid),
    .grant_idx   (rd_gnt_idx)
  );

  // Read FSM next state and registered outputs. The owner index is latched
  // at grant, so a receiver dropping its req mid-flight still gets the word.
  always_comb begin
    state_d    = state_q;
    rd_idx_d   = rd_idx_q;
    lat_cnt_d  = lat_cnt_q;
    rd_en_d    = 1'b0;
    rd_valid_d = '0;
    rd_data_d  = rd_data_q;
    rd_ptr_d   = rd_ptr_q;
    rd_count_d = rd_count_q;
    unique case (state_q)
      IDLE: begin
        if (rd_gnt_valid) begin
          state_d  = ISSUE;
          rd_idx_d = rd_gnt_idx;
          rd_en_d  = 1'b1;
        end
      end
      ISSUE: begin
        state_d   = WAIT;
        lat_cnt_d = LCW'(RD_LATENCY - 1);
      end
      WAIT: begin
        if (lat_cnt_q == '0) state_d = DELIVER;
        else                 lat_cnt_d = lat_cnt_q - 1'b1;
      end
      DELIVER: begin
        state_d    = IDLE;
        rd_data_d  = fifo_rd_data;
        rd_valid_d = NUM_RD'(1) << rd_idx_q;
        rd_ptr_d   = (rd_idx_q == RIW'(NUM_RD - 1)) ? '0 : rd_idx_q + 1'b1;
        rd_count_d = rd_count_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read-side registers; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rd_idx_q   <= '0;
      lat_cnt_q  <= '0;
      rd_en_q    <= 1'b0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      rd_ptr_q   <= '0;
      rd_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_idx_q   <= rd_idx_d;
      lat_cnt_q  <= lat_cnt_d;
      rd_en_q    <= rd_en_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign wr_ack       = wr_ack_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_word_q;
  assign wr_count     = wr_count_q;
  assign fifo_rd_en   = rd_en_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign rd_count     = rd_count_q;

endmodule

// File: tb/tb_argo_chan_arbiter.sv
// Bench for argo_chan_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model and
// a queue-based FIFO standing in for argo_fifo.
module tb_argo_chan_arbiter;

  localparam int NW = 4;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int L  = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [NW-1:0]    wr_req;
  logic [DW-1:0]    snd_data [NW];
  wire  [NW*DW-1:0] wr_data;
  logic [NW-1:0]    wr_ack;
  logic [NR-1:0]    rd_req;
  logic [NR-1:0]    rd_valid;
  logic [DW-1:0]    rd_data;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_wr_data;
  logic             fifo_full;
  logic             fifo_rd_en;
  logic [DW-1:0]    fifo_rd_data;
  logic             fifo_empty;
  logic [31:0]      wr_count;
  logic [31:0]      rd_count;

  for (genvar g = 0; g < NW; g++) begin : g_pack
    assign wr_data[g*DW +: DW] = snd_data[g];
  end

  argo_chan_arbiter #(
    .NUM_WR(NW), .NUM_RD(NR), .DATA_WIDTH(DW), .RD_LATENCY(L)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req       (wr_req),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .rd_req       (rd_req),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .wr_count     (wr_count),
    .rd_count     (rd_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------- FIFO stand-in
  logic [DW-1:0] fifo_q [$];
  int            fifo_depth  = 8;
  bit            force_full  = 1'b0;
  bit            prev_full   = 1'b0;
  bit            prev_empty  = 1'b1;
  int            rd_en_pulses = 0;

  task automatic fifo_drive();
    fifo_empty = (fifo_q.size() == 0);
    fifo_full  = force_full || (fifo_q.size() >= fifo_depth);
  endtask

  // ------------------------------------------------------- reference model
  // Write: oldest-pointer round robin, one issue per two cycles, never when full.
  // Read: one transaction at a time; the word lands RD_LATENCY+2 clocks after
  // the grant (rd_en cycle, FIFO latency, one register stage).
  logic          m_wr_en;
  logic [DW-1:0] m_wr_data;
  logic [NW-1:0] m_ack;
  int            m_wr_ptr;
  logic [31:0]   m_wr_count;
  logic          m_rd_en;
  logic [NR-1:0] m_rd_valid;
  logic [DW-1:0] m_rd_data;
  int            m_rd_ptr;
  logic [31:0]   m_rd_count;
  bit            m_busy;
  int            m_who;
  int            m_age;

  task automatic model_reset();
    m_wr_en = 0; m_wr_data = '0; m_ack = '0; m_wr_ptr = 0; m_wr_count = '0;
    m_rd_en = 0; m_rd_valid = '0; m_rd_data = '0; m_rd_ptr = 0; m_rd_count = '0;
    m_busy = 0; m_who = 0; m_age = 0;
  endtask

  task automatic model_step();
    bit found = 0;
    int win = 0;
    if (!fifo_full && !m_wr_en) begin
      for (int s = 0; s < NW; s++) begin
        int c = (m_wr_ptr + s) % NW;
        if (!found && wr_req[c] && !m_ack[c]) begin found = 1; win = c; end
      end
    end
    if (found) begin
      m_wr_en = 1; m_wr_data = snd_data[win]; m_ack = NW'(1) << win;
      m_wr_ptr = (win + 1) % NW; m_wr_count++;
    end else begin
      m_wr_en = 0; m_ack = '0;
    end

    m_rd_en = 0; m_rd_valid = '0;
    if (m_busy) begin
      m_age++;
      if (m_age == L + 2) begin
        m_rd_data = fifo_rd_data;
        m_rd_valid = NR'(1) << m_who;
        m_rd_ptr = (m_who + 1) % NR;
        m_rd_count++;
        m_busy = 0;
      end
    end else if (!fifo_empty && rd_req != '0) begin
      found = 0;
      for (int s = 0; s < NR; s++) begin
        int c = (m_rd_ptr + s) % NR;
        if (!found && rd_req[c]) begin found = 1; m_who = c; end
      end
      m_busy = 1; m_age = 0; m_rd_en = 1;
    end
  endtask

  // ------------------------------------------------------------- stimulus
  bit [NR-1:0] rd_keep = '0;
  int          obs_idx [$];
  logic [DW-1:0] obs_data [$];

  task automatic compare_all();
    check("wr_ack", wr_ack, m_ack);
    check("fifo_wr_en", fifo_wr_en, m_wr_en);
    check("fifo_wr_data", fifo_wr_data, m_wr_data);
    check("wr_count", wr_count, m_wr_count);
    check("rd_valid", rd_valid, m_rd_valid);
    check("rd_data", rd_data, m_rd_data);
    check("fifo_rd_en", fifo_rd_en, m_rd_en);
    check("rd_count", rd_count, m_rd_count);
  endtask

  task automatic tick();
    logic          s_wr_en, s_rd_en;
    logic [DW-1:0] s_wr_data;
    @(posedge clk);
    s_wr_en = fifo_wr_en; s_rd_en = fifo_rd_en; s_wr_data = fifo_wr_data;
    if (rst) model_step(); else model_reset();
    // These enables were decided on the flags sampled at the previous edge.
    if (s_rd_en) begin rd_en_pulses++; check("rd_en_while_empty", prev_empty, 1'b0); end
    if (s_wr_en) check("wr_en_while_full", prev_full, 1'b0);
    prev_full = fifo_full; prev_empty = fifo_empty;
    #1;
    if (s_rd_en && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
    if (s_wr_en && fifo_q.size() < fifo_depth) fifo_q.push_back(s_wr_data);
    fifo_drive();
    @(negedge clk);
    compare_all();
    for (int j = 0; j < NR; j++) if (rd_valid[j]) begin obs_idx.push_back(j); obs_data.push_back(rd_data); end
    for (int i = 0; i < NW; i++) if (m_ack[i]) wr_req[i] = 1'b0;
    for (int j = 0; j < NR; j++) if (m_rd_valid[j] && !rd_keep[j]) rd_req[j] = 1'b0;
  endtask

  task automatic reset_checks();
    check("rst_wr_ack", wr_ack, 0);
    check("rst_fifo_wr_en", fifo_wr_en, 0);
    check("rst_fifo_wr_data", fifo_wr_data, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_fifo_rd_en", fifo_rd_en, 0);
    check("rst_rd_count", rd_count, 0);
  endtask

  // Called at a negedge; asserts reset, checks outputs cleared, releases.
  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    reset_checks();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic run_until_deliveries(input int want, input int budget, input string tag);
    int cyc = 0;
    while (obs_idx.size() < want && cyc < budget) begin tick(); cyc++; end
    check(tag, obs_idx.size(), want);
  endtask

  initial begin
    rst = 1'b0;
    wr_req = '0; rd_req = '0;
    for (int i = 0; i < NW; i++) snd_data[i] = '0;
    fifo_rd_data = '0;
    fifo_drive();
    model_reset();
    #1;
    reset_checks();
    tick();
    tick();
    rst = 1'b1;

    // 1: single write into an empty FIFO
    snd_data[0] = 32'h11; wr_req[0] = 1'b1;
    tick();
    check("t1_ack", wr_ack, 4'b0001);
    check("t1_wr_en", fifo_wr_en, 1);
    tick(); tick();
    check("t1_wr_count", wr_count, 1);
    check("t1_fifo_words", fifo_q.size(), 1);
    check("t1_fifo_word0", fifo_q[0], 32'h11);

    // 2: three simultaneous writers from a fresh pointer
    do_reset();
    snd_data[0] = 32'hA0; snd_data[1] = 32'hA1; snd_data[2] = 32'hA2;
    wr_req = 4'b0111;
    tick(); check("t2_ack0", wr_ack, 4'b0001);
    tick(); check("t2_gap0", wr_ack, 4'b0000);
    tick(); check("t2_ack1", wr_ack, 4'b0010);
    tick(); tick(); check("t2_ack2", wr_ack, 4'b0100);
    tick();
    check("t2_fifo_words", fifo_q.size(), 4);
    check("t2_fifo_a0", fifo_q[1], 32'hA0);
    check("t2_fifo_a1", fifo_q[2], 32'hA1);
    check("t2_fifo_a2", fifo_q[3], 32'hA2);

    // 3: write held off while full, issued one cycle after full drops
    force_full = 1'b1; fifo_drive();
    snd_data[3] = 32'h33; wr_req[3] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t3_no_ack_full", wr_ack, 4'b0000);
    end
    force_full = 1'b0; fifo_drive();
    tick();
    check("t3_ack_after_full", wr_ack, 4'b1000);
    check("t3_data_after_full", fifo_wr_data, 32'h33);
    tick();

    // 4: two receivers requesting continuously against words 5,6,7
    do_reset();
    fifo_q.delete();
    fifo_q.push_back(32'd5); fifo_q.push_back(32'd6); fifo_q.push_back(32'd7);
    fifo_drive();
    obs_idx.delete(); obs_data.delete(); rd_en_pulses = 0;
    rd_keep = 4'b1010; rd_req = 4'b1010;
    run_until_deliveries(3, 40, "t4_deliveries");
    rd_keep = '0; rd_req = '0;
    if (obs_idx.size() == 3) begin
      check("t4_idx0", obs_idx[0], 1); check("t4_dat0", obs_data[0], 5);
      check("t4_idx1", obs_idx[1], 3); check("t4_dat1", obs_data[1], 6);
      check("t4_idx2", obs_idx[2], 1); check("t4_dat2", obs_data[2], 7);
    end
    tick(); tick();
    check("t4_rd_en_pulses", rd_en_pulses, 3);
    check("t4_rd_count", rd_count, 3);

    // 5: reset while a read is waiting on the FIFO
    fifo_q.push_back(32'h77); fifo_q.push_back(32'h88); fifo_drive();
    rd_req[2] = 1'b1;
    begin
      int cyc = 0;
      while (!(m_busy && m_age == 1) && cyc < 10) begin tick(); cyc++; end
      check("t5_reached_wait", (m_busy && m_age == 1), 1);
    end
    obs_idx.delete(); obs_data.delete();
    do_reset();
    rd_req[0] = 1'b1;
    run_until_deliveries(1, 20, "t5_deliveries");
    if (obs_idx.size() == 1) begin
      check("t5_idx", obs_idx[0], 0);
      check("t5_dat", obs_data[0], 32'h88);
    end
    rd_req = '0;
    tick(); tick();

    // 6: read waits on an empty FIFO while a write fills it
    obs_idx.delete(); obs_data.delete();
    rd_req[0] = 1'b1; snd_data[2] = 32'h55; wr_req[2] = 1'b1;
    tick();
    check("t6_write_first", wr_ack, 4'b0100);
    check("t6_no_early_read", fifo_rd_en, 0);
    run_until_deliveries(1, 20, "t6_deliveries");
    if (obs_idx.size() == 1) begin
      check("t6_idx", obs_idx[0], 0);
      check("t6_dat", obs_data[0], 32'h55);
    end
    tick();

    // Random traffic: small FIFO, spurious full, receivers sometimes give up.
    fifo_depth = 4;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NW; i++) begin
        if (!wr_req[i] && $urandom_range(0, 9) < 3) begin
          snd_data[i] = $urandom(); wr_req[i] = 1'b1;
        end
      end
      for (int j = 0; j < NR; j++) begin
        if (!rd_req[j] && $urandom_range(0, 9) < 3) rd_req[j] = 1'b1;
        else if (rd_req[j] && $urandom_range(0, 49) == 0) rd_req[j] = 1'b0;
      end
      force_full = ($urandom_range(0, 9) == 0);
      fifo_drive();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
